mvu_apb_requester: RTL and testbench
====================================

# mvu_apb_requester

Clocked APB requester that turns CSR access requests from the control core into APB SETUP/ACCESS transfers toward the MVU CSR completer. It queues up to two requests and builds `paddr = {mvu_id, csr}`, with the 12-bit CSR offset in the low bits. It waits on `pready` with a bounded timeout and returns one response per request: read data, error and timeout flags. The block sits between the control core's CSR port and the APB bus that configures the MVU array.

## Interface
Parameters:
- `BMVUA`, 3: width of the MVU index.
- `APB_ADDR_WIDTH`, `BMVUA+12`: width of `paddr`.
- `APB_DATA_WIDTH`, 32: width of `pwdata` and `prdata`.
- `TIMEOUT`, 255: maximum ACCESS wait cycles; 0 disables the timeout. Width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_mvu_id`  in  BMVUA  target MVU index.
- `req_csr`  in  12  CSR offset.
- `req_wdata`  in  APB_DATA_WIDTH  write data.
- `rsp_valid`  out  1  response held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  APB_DATA_WIDTH  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  `pslverr` seen, or timeout.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `paddr`  out  APB_ADDR_WIDTH  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB write.
- `pwdata`  out  APB_DATA_WIDTH  APB write data.
- `prdata`  in  APB_DATA_WIDTH  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB error.

## Operation
- Request FIFO: 2 entries, each `{write, mvu_id, csr, wdata}`.
  - `req_ready = !full`, registered; no fall-through from a same-cycle pop.
  - Pop happens on the IDLE→SETUP transition; the head is loaded into the `paddr`/`pwrite`/`pwdata` registers.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE→SETUP when FIFO is non-empty and `(!rsp_valid | rsp_ready)`. This guarantees a free response slot at completion.
  - Otherwise the FSM stays in IDLE with `psel=0`.
- SETUP: `psel=1`, `penable=0`; always moves to ACCESS next cycle.
- ACCESS: `psel=1`, `penable=1`.
  - If `pready=1`, the transfer completes and the FSM returns to IDLE.
  - If `pready=0`, the FSM stays in ACCESS and the wait counter increments.
- Completion loads the response register:
  - `rsp_valid=1`.
  - `rsp_rdata = pwrite ? 0 : prdata`.
  - `rsp_err = pslverr`.
  - `rsp_timeout = 0`.
- Timeout (TIMEOUT>0): the wait counter resets on entry to ACCESS.
  - Abort when the counter reaches TIMEOUT with `pready` still 0: `psel=penable=0` next cycle, FSM goes to IDLE.
  - Abort response: `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the final ACCESS cycle; they hold their last value in IDLE.
- The response register clears `rsp_valid` on `rsp_valid & rsp_ready`. Data fields hold until the next load.
- FIFO push and pop in the same cycle: allowed when not full; occupancy is unchanged.
- Responses are returned in request order; exactly one response per accepted request.

## Timing
- Reset, asynchronous: while `rst_n=0`, every output is 0, including `req_ready`. FIFO is emptied, FSM goes to IDLE, wait counter is 0.
  - First rising edge after deassertion: `req_ready=1`.
  - Reset in SETUP or ACCESS drops `psel`/`penable` immediately, without waiting for a clock. The pending request and its response are discarded.
- Latency, with the request accepted in cycle T and FIFO empty:
  - IDLE in T+1, SETUP in T+2, ACCESS in T+3.
  - With `pready=1` in T+3, `rsp_valid=1` in T+4.
  - Each extra `pready=0` cycle adds one cycle.
- Throughput with `pready=1` and `rsp_ready=1`: one transfer per 3 cycles (SETUP, ACCESS, IDLE).
- Response stall: while `rsp_valid & !rsp_ready`, no new SETUP starts. The FIFO still accepts requests until full.
- Timeout: with `pready` stuck at 0, ACCESS lasts TIMEOUT+1 cycles. `rsp_valid` rises in the following cycle.

## Test plan
- Single write: `mvu_id=2`, `csr=0x010`, `wdata=0x0000_00A5`, `pready=1`.
  - `paddr=0x2010`, `pwrite=1`, `pwdata=0xA5`; SETUP in T+2, ACCESS in T+3.
  - `rsp_valid` in T+4 with `rsp_err=0`, `rsp_rdata=0`.
- Read with wait states: `mvu_id=7`, `csr=0x3F0`; `pready` low for 3 ACCESS cycles, `prdata=0xDEAD_BEEF`.
  - ACCESS lasts 4 cycles; `paddr=0x73F0` stable throughout.
  - `rsp_rdata=0xDEADBEEF`, `rsp_err=0`.
- Burst: `req_valid` held for 4 requests, `rsp_ready=0` at first.
  - One transfer completes, then `req_ready=0` once 2 entries are queued; `psel` stays 0 while the response is unconsumed.
  - Raise `rsp_ready`: all 4 responses arrive in order, 3 cycles apart.
- Timeout, TIMEOUT=8, `pready` stuck at 0:
  - ACCESS lasts 9 cycles; `psel=0` the following cycle.
  - Response has `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`; the next queued request then proceeds normally.
- Slave error: `pslverr=1` together with `pready=1` → `rsp_err=1`, `rsp_timeout=0`.
- Reset mid-ACCESS: assert `rst_n=0` between clock edges.
  - `psel`, `penable`, `rsp_valid`, `req_ready` and `busy` go to 0 before the next edge.
  - After release: no response for the dropped request, and the FIFO is empty.

Source files
------------

// File: rtl/mvu_apb_requester.sv
`default_nettype none
// ============================================================================
//  Module   : mvu_apb_requester
//  Purpose  : APB requester for the MVU CSR completer. Queues up to two CSR
//             access requests from the control core, runs each one as an APB
//             SETUP/ACCESS transfer to paddr = {mvu_id, csr}, bounds the
//             ACCESS wait with a timeout and returns one response per request.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock, asynchronous active-low reset
//    req_*               request channel (valid/ready, write, mvu_id, csr, wdata)
//    rsp_*               response channel (valid/ready, rdata, err, timeout)
//    busy                FIFO non-empty or transfer in flight
//    paddr..pwdata       APB request outputs
//    prdata/pready/
//    pslverr             APB completer inputs
// ============================================================================
module mvu_apb_requester #(
    parameter int BMVUA          = 3,
    parameter int APB_ADDR_WIDTH = BMVUA + 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [BMVUA-1:0]          req_mvu_id,
    input  logic [11:0]               req_csr,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    // A zero TIMEOUT disables the abort; keep the counter at least one bit wide.
    localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  C_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_wait;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_rsp_valid;
    logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      r_rsp_timeout;

    // ------------------------------------------------------------------------
    // Two-entry request FIFO
    // ------------------------------------------------------------------------
    logic                      r_fifo_write [2];
    logic [APB_ADDR_WIDTH-1:0] r_fifo_addr  [2];
    logic [APB_DATA_WIDTH-1:0] r_fifo_wdata [2];
    logic                      r_wptr;
    logic                      r_rptr;
    logic [1:0]                r_count;
    logic                      r_req_ready;

    logic                      w_push;
    logic                      w_pop;
    logic [1:0]                w_count_nxt;
    logic [APB_ADDR_WIDTH-1:0] w_req_addr;

    assign w_req_addr  = APB_ADDR_WIDTH'({req_mvu_id, req_csr});
    assign w_push      = req_valid & r_req_ready;
    // Starting only when the response slot is free (or being freed) means a
    // completion can always be written without back-pressure.
    assign w_pop       = (r_state == S_IDLE) && (r_count != 2'd0) && (!r_rsp_valid || rsp_ready);
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_req_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count     <= w_count_nxt;
            // Registered so a pop in the same cycle never makes room early.
            r_req_ready <= (w_count_nxt != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_write[r_wptr] <= req_write;
            r_fifo_addr[r_wptr]  <= w_req_addr;
            r_fifo_wdata[r_wptr] <= req_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // APB transfer FSM with registered bus and response outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wait        <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state  <= S_SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= r_fifo_addr[r_rptr];
                        r_pwrite <= r_fifo_write[r_rptr];
                        r_pwdata <= r_fifo_wdata[r_rptr];
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end
                S_ACCESS: begin
                    if (pready) begin
                        r_state       <= S_IDLE;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                    end else if ((TIMEOUT > 0) && (r_wait == C_TIMEOUT)) begin
                        r_state       <= S_IDLE;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_count != 2'd0) || (r_state != S_IDLE);
    assign paddr       = r_paddr;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_mvu_apb_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mvu_apb_requester
//  Purpose  : Self-checking bench for mvu_apb_requester. A behavioural APB
//             completer (CSR memory, address-based error/stall rules) sits on
//             the bus; a transaction-level model predicts every response.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mvu_apb_requester;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_mvu_id = '0;
    logic [11:0] req_csr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [14:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    mvu_apb_requester #(
        .BMVUA          (3),
        .APB_ADDR_WIDTH (15),
        .APB_DATA_WIDTH (32),
        .TIMEOUT        (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_mvu_id  (req_mvu_id),
        .req_csr     (req_csr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Completer: csr 0xBAD never answers, csr 0xFxx answers with an error,
    // everything else is a plain read/write memory. cfg_wait < 0 = random.
    // ------------------------------------------------------------------------
    int          cfg_wait = 0;
    logic [31:0] slave_mem [logic [14:0]];
    bit          s_in_acc = 1'b0;
    int          s_cnt    = 0;
    int          s_waits  = 0;

    always @(negedge clk) begin
        if (psel && penable) begin
            if (!s_in_acc) begin
                s_in_acc = 1'b1;
                s_cnt    = 0;
                s_waits  = (cfg_wait >= 0) ? cfg_wait : int'($urandom_range(0, 3));
            end else begin
                s_cnt++;
            end
            if (paddr[11:0] == 12'hBAD || s_cnt < s_waits) begin
                pready  = 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata  = $urandom;
            end else begin
                pready  = 1'b1;
                pslverr = (paddr[11:8] == 4'hF);
                if (pwrite) begin
                    prdata = $urandom;
                    if (!pslverr) slave_mem[paddr] = pwdata;
                end else begin
                    prdata = slave_mem.exists(paddr) ? slave_mem[paddr] : 32'h0;
                end
            end
        end else begin
            s_in_acc = 1'b0;
            pready   = 1'($urandom_range(0, 1));
            pslverr  = 1'b0;
            prdata   = $urandom;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: every accepted request yields one expected response,
    // delivered in order.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    logic [31:0] model_mem [logic [14:0]];
    exp_t        exp_q [$];
    int          hs_q  [$];
    exp_t        m_e;
    logic [14:0] m_a;
    exp_t        r_e;

    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            m_a      = {req_mvu_id, req_csr};
            m_e.to   = (req_csr == 12'hBAD);
            m_e.err  = m_e.to || (req_csr[11:8] == 4'hF);
            m_e.rdata = 32'h0;
            if (!m_e.to) begin
                if (req_write) begin
                    if (!m_e.err) model_mem[m_a] = req_wdata;
                end else begin
                    m_e.rdata = model_mem.exists(m_a) ? model_mem[m_a] : 32'h0;
                end
            end
            exp_q.push_back(m_e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            hs_q.push_back(cyc);
            check("rsp_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                r_e = exp_q.pop_front();
                check("rsp_rdata",   rsp_rdata,   r_e.rdata);
                check("rsp_err",     rsp_err,     r_e.err);
                check("rsp_timeout", rsp_timeout, r_e.to);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic send(input logic w, input logic [2:0] id, input logic [11:0] csr, input logic [31:0] wd);
        int   n = 0;
        logic acc;
        req_write  = w;
        req_mvu_id = id;
        req_csr    = csr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        do begin
            acc = req_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        req_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        rsp_ready = 1'b1;
        while ((busy || rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy || rsp_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic measure_access(input logic [14:0] a, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (psel && penable) begin
                n++;
                check("access_paddr", paddr, a);
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    task automatic rand_req();
        int k = int'($urandom_range(0, 9));
        req_write  = 1'($urandom_range(0, 1));
        req_mvu_id = 3'($urandom_range(0, 7));
        case (k)
            0:       req_csr = 12'hBAD;
            1, 2:    req_csr = 12'hF04;
            default: req_csr = 12'($urandom_range(0, 3) * 4);
        endcase
        req_wdata = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    int          n_acc;
    int          idx;
    int          hs_before;
    logic        acc;
    logic        b_w  [4];
    logic [31:0] b_wd [4];

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_psel",      psel,      0);
        check("rst_penable",   penable,   0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_paddr",     paddr,     0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", req_ready, 1);

        // Single write with exact latency
        cfg_wait = 0;
        send(1'b1, 3'd2, 12'h010, 32'h0000_00A5);
        @(negedge clk);                                     // T+1
        check("t1_psel", psel, 0);
        check("t1_busy", busy, 1);
        @(negedge clk);                                     // T+2
        check("t2_psel",    psel,    1);
        check("t2_penable", penable, 0);
        check("t2_paddr",   paddr,   15'h2010);
        check("t2_pwrite",  pwrite,  1);
        check("t2_pwdata",  pwdata,  32'hA5);
        @(negedge clk);                                     // T+3
        check("t3_psel",    psel,    1);
        check("t3_penable", penable, 1);
        @(negedge clk);                                     // T+4
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_err",   rsp_err,   0);
        check("t4_rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        wait_idle();

        // Read with three wait states
        send(1'b1, 3'd7, 12'h3F0, 32'hDEAD_BEEF);
        wait_idle();
        cfg_wait = 3;
        send(1'b0, 3'd7, 12'h3F0, 32'h0);
        measure_access(15'h73F0, n);
        check("wait_access_len", n, 4);
        @(posedge clk); #1;
        wait_idle();

        // Burst with response stall
        cfg_wait  = 0;
        rsp_ready = 1'b0;
        hs_q.delete();
        for (int i = 0; i < 4; i++) begin
            b_w[i]  = 1'($urandom_range(0, 1));
            b_wd[i] = $urandom;
        end
        idx = 0;
        req_write = b_w[0]; req_mvu_id = 3'd0; req_csr = 12'h100; req_wdata = b_wd[0];
        req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            acc = req_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    req_write = b_w[idx]; req_mvu_id = 3'(idx); req_csr = 12'(12'h100 + idx * 4); req_wdata = b_wd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("burst_accepted", idx, 3);
        check("burst_full",     req_ready, 0);
        check("burst_psel",     psel, 0);
        check("burst_rsp_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 4; c++) begin
            acc = req_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        wait_idle();
        check("burst_rsp_count", hs_q.size(), 4);
        if (hs_q.size() == 4) begin
            for (int i = 0; i < 3; i++) check("burst_rsp_spacing", hs_q[i+1] - hs_q[i], 3);
        end

        // Timeout followed by a normal request
        send(1'b0, 3'd1, 12'hBAD, 32'h0);
        send(1'b1, 3'd1, 12'h044, $urandom);
        measure_access(15'h1BAD, n);
        check("timeout_access_len", n, TO + 1);
        check("timeout_psel_drop",  psel, 0);
        check("timeout_rsp_valid",  rsp_valid, 1);
        @(posedge clk); #1;
        wait_idle();

        // Completer error on write and read
        send(1'b1, 3'd5, 12'hF10, 32'h1234_5678);
        send(1'b0, 3'd5, 12'hF10, 32'h0);
        wait_idle();

        // Randomized traffic with random response back-pressure
        cfg_wait  = -1;
        n_acc     = 0;
        req_valid = 1'b0;
        for (int c = 0; c < 3000 && n_acc < 20; c++) begin
            if (!req_valid && $urandom_range(0, 1) == 1) begin
                rand_req();
                req_valid = 1'b1;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("rand_accepted", n_acc, 20);
        wait_idle();
        check("rand_queue_drained", exp_q.size(), 0);

        // Reset in the middle of ACCESS
        cfg_wait = 5;
        send(1'b0, 3'd3, 12'h100, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(psel && penable) && n < 20);
        check("mid_reset_in_access", psel && penable, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_psel",      psel,      0);
        check("mid_reset_penable",   penable,   0);
        check("mid_reset_rsp_valid", rsp_valid, 0);
        check("mid_reset_req_ready", req_ready, 0);
        check("mid_reset_busy",      busy,      0);
        exp_q.delete();
        hs_before = hs_q.size();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", req_ready, 1);
        check("rel_busy",      busy,      0);
        repeat (10) @(posedge clk);
        #1;
        check("rel_no_response", hs_q.size(), hs_before);
        check("rel_rsp_valid",   rsp_valid, 0);
        check("rel_fifo_empty",  busy,      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
